// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset/exception addresses, next-PC source encoding,
// and a small word-alignment helper used by the fetch unit.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

  // Next-PC source, listed from highest to lowest priority
  typedef enum logic [2:0] {
    SRC_EXC  = 3'd0,
    SRC_ERET = 3'd1,
    SRC_BR   = 3'd2,
    SRC_JMP  = 3'd3,
    SRC_JR   = 3'd4,
    SRC_SEQ  = 3'd5
  } npc_src_t;

  // Clear the byte-offset bits so a fetch address is always word aligned
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // True when an address is not a multiple of four
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/npc_ras_stack.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; a pop when empty changes nothing. ovf/unf are same-cycle flags.
module npc_ras_stack #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [31:0]              push_data,
  output logic [31:0]              top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [31:0]   mem_r [DEPTH];
  logic [PW-1:0] sp_r;
  logic [PW-1:0] top_idx_s;
  logic [CW-1:0] count_r;
  logic          full_s;
  logic          empty_s;

  assign full_s    = (count_r == CNT_FULL);
  assign empty_s   = (count_r == {CW{1'b0}});
  assign top_idx_s = sp_r - PTR_ONE;
  assign top       = mem_r[top_idx_s];
  assign count     = count_r;
  assign ovf       = push & full_s;
  assign unf       = pop & ~push & empty_s;

  // Stack pointer and occupancy; push wins over a simultaneous pop
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_r    <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else if (push) begin
      sp_r    <= sp_r + PTR_ONE;
      count_r <= full_s ? count_r : (count_r + CNT_ONE);
    end else if (pop && !empty_s) begin
      sp_r    <= sp_r - PTR_ONE;
      count_r <= count_r - CNT_ONE;
    end else begin
      sp_r    <= sp_r;
      count_r <= count_r;
    end
  end

  // Entry storage; contents are never cleared, occupancy tracks validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[sp_r] <= push_data;
    end
  end

endmodule

// File: rtl/npc_unit.sv
// Next-PC unit: selects the next fetch address by fixed priority, keeps a
// predictive return-address stack, and raises one-cycle event pulses.
module npc_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int          RAS_DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         br,
  input  logic                         zero,
  input  logic [15:0]                  br_off,
  input  logic                         j,
  input  logic                         jal,
  input  logic [25:0]                  j_index,
  input  logic                         jr,
  input  logic                         ret,
  input  logic [31:0]                  jr_target,
  input  logic                         exc,
  input  logic                         eret,
  input  logic [31:0]                  epc,
  output logic [31:0]                  pc,
  output logic [31:0]                  pc_4,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_mispredict,
  output logic                         ras_ovf,
  output logic                         ras_unf,
  output logic                         addr_err
);

  npc_src_t    src_s;
  logic [31:0] next_pc_s;
  logic [31:0] br_target_s;
  logic        misalign_s;
  logic        advance_s;
  logic        push_s;
  logic        pop_s;
  logic        mispredict_s;
  logic [31:0] ras_top_s;
  logic        ras_ovf_s;
  logic        ras_unf_s;

  assign pc_4        = pc + 32'd4;
  assign br_target_s = pc_4 + {{14{br_off[15]}}, br_off, 2'b00};

  // An exception is taken even while the pipeline is stalled
  assign advance_s = exc | ~stall;

  // Priority select of the next-PC source
  always_comb begin
    src_s = SRC_SEQ;
    if (exc) begin
      src_s = SRC_EXC;
    end else if (eret) begin
      src_s = SRC_ERET;
    end else if (br && zero) begin
      src_s = SRC_BR;
    end else if (j || jal) begin
      src_s = SRC_JMP;
    end else if (jr || ret) begin
      src_s = SRC_JR;
    end else begin
      src_s = SRC_SEQ;
    end
  end

  // Target mux; register targets are forced word aligned and flagged
  always_comb begin
    next_pc_s  = pc_4;
    misalign_s = 1'b0;
    case (src_s)
      SRC_EXC:  next_pc_s = EXC_VECTOR;
      SRC_ERET: begin
        next_pc_s  = word_align(epc);
        misalign_s = is_misaligned(epc);
      end
      SRC_BR:   next_pc_s = br_target_s;
      SRC_JMP:  next_pc_s = {pc[31:28], j_index, 2'b00};
      SRC_JR:   begin
        next_pc_s  = word_align(jr_target);
        misalign_s = is_misaligned(jr_target);
      end
      SRC_SEQ:  next_pc_s = pc_4;
      default:  next_pc_s = pc_4;
    endcase
  end

  // jal only links when it actually steers the PC; ret is ignored alongside jal
  assign push_s = advance_s & (src_s == SRC_JMP) & jal;
  assign pop_s  = advance_s & (src_s == SRC_JR) & ret & ~jal;

  // The stack only predicts: a miss is reported, the PC still follows jr_target
  assign mispredict_s = pop_s & (ras_unf_s | (ras_top_s != jr_target));

  npc_ras_stack #(
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc_4),
    .top       (ras_top_s),
    .count     (ras_count),
    .ovf       (ras_ovf_s),
    .unf       (ras_unf_s)
  );

  // PC register and one-cycle event pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= RESET_PC;
      ras_mispredict <= 1'b0;
      ras_ovf        <= 1'b0;
      ras_unf        <= 1'b0;
      addr_err       <= 1'b0;
    end else begin
      pc             <= advance_s ? next_pc_s : pc;
      ras_mispredict <= mispredict_s;
      ras_ovf        <= ras_ovf_s;
      ras_unf        <= ras_unf_s & pop_s;
      addr_err       <= advance_s & misalign_s;
    end
  end

endmodule

// File: tb/tb_npc_unit.sv
// Directed self-checking bench for npc_unit with default parameters.
module tb_npc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, br, zero, j, jal, jr, ret, exc, eret;
  logic [15:0] br_off;
  logic [25:0] j_index;
  logic [31:0] jr_target, epc;
  logic [31:0] pc, pc_4;
  logic [3:0]  ras_count;
  logic        ras_mispredict, ras_ovf, ras_unf, addr_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [31:0] push_val [9];
  logic [31:0] exp_pc;

  npc_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .br             (br),
    .zero           (zero),
    .br_off         (br_off),
    .j              (j),
    .jal            (jal),
    .j_index        (j_index),
    .jr             (jr),
    .ret            (ret),
    .jr_target      (jr_target),
    .exc            (exc),
    .eret           (eret),
    .epc            (epc),
    .pc             (pc),
    .pc_4           (pc_4),
    .ras_count      (ras_count),
    .ras_mispredict (ras_mispredict),
    .ras_ovf        (ras_ovf),
    .ras_unf        (ras_unf),
    .addr_err       (addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    stall = 1'b0; br = 1'b0; zero = 1'b0; br_off = 16'h0000;
    j = 1'b0; jal = 1'b0; j_index = 26'h0; jr = 1'b0; ret = 1'b0;
    jr_target = 32'h0; exc = 1'b0; eret = 1'b0; epc = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_cnt", 32'(ras_count), 32'd0);
    chk("rst_pulses", {28'h0, ras_mispredict, ras_ovf, ras_unf, addr_err}, 32'd0);
    reset = 1'b0;

    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("seq_pc", pc, 32'h0000_3000 + 32'(4 * i));
    end
    chk("pc_4", pc_4, 32'h0000_3010);
    tick();
    chk("seq_pc4", pc, 32'h0000_3010);

    // Taken backward branch then not-taken from the same PC
    br = 1'b1; zero = 1'b1; br_off = 16'hFFFC;
    tick();
    chk("br_taken", pc, 32'h0000_3004);
    clear_inputs(); jr = 1'b1; jr_target = 32'h0000_3010;
    tick();
    chk("jr_3010", pc, 32'h0000_3010);
    clear_inputs(); br = 1'b1; zero = 1'b0; br_off = 16'hFFFC;
    tick();
    chk("br_not", pc, 32'h0000_3014);

    // jal / ret round trip
    clear_inputs(); jr = 1'b1; jr_target = 32'h0000_3000;
    tick();
    chk("jr_3000", pc, 32'h0000_3000);
    clear_inputs(); jal = 1'b1; j_index = 26'h0000C10;
    tick();
    chk("jal_pc", pc, 32'h0000_3040);
    chk("jal_cnt", 32'(ras_count), 32'd1);
    clear_inputs(); ret = 1'b1; jr_target = 32'h0000_3004;
    tick();
    chk("ret_pc", pc, 32'h0000_3004);
    chk("ret_cnt", 32'(ras_count), 32'd0);
    chk("ret_mp", 32'(ras_mispredict), 32'd0);

    // Nine pushes into an eight-entry stack
    exp_pc = 32'h0000_3004;
    for (int i = 0; i < 9; i++) begin
      clear_inputs(); jal = 1'b1; j_index = 26'h0000C00 + 26'(4 * i);
      push_val[i] = exp_pc + 32'd4;
      exp_pc = 32'h0000_3000 + 32'(16 * i);
      tick();
      chk("ovf_pc", pc, exp_pc);
      chk("ovf_pulse", 32'(ras_ovf), (i == 8) ? 32'd1 : 32'd0);
      chk("ovf_cnt", 32'(ras_count), (i >= 7) ? 32'd8 : 32'(i + 1));
    end
    // Eight clean returns, newest first; the oldest push was overwritten
    for (int k = 8; k >= 1; k--) begin
      clear_inputs(); ret = 1'b1; jr_target = push_val[k];
      tick();
      chk("pop_pc", pc, push_val[k]);
      chk("pop_mp", 32'(ras_mispredict), 32'd0);
      chk("pop_unf", 32'(ras_unf), 32'd0);
      chk("pop_cnt", 32'(ras_count), 32'(k - 1));
    end
    clear_inputs(); ret = 1'b1; jr_target = push_val[0];
    tick();
    chk("unf_pc", pc, 32'h0000_3008);
    chk("unf_pulse", 32'(ras_unf), 32'd1);
    chk("unf_mp", 32'(ras_mispredict), 32'd1);
    chk("unf_cnt", 32'(ras_count), 32'd0);
    clear_inputs();
    tick();
    chk("pulse_drop", {29'h0, ras_mispredict, ras_ovf, ras_unf}, 32'd0);
    chk("idle_pc", pc, 32'h0000_300C);

    // Return to a different address than predicted
    clear_inputs(); jal = 1'b1; j_index = 26'h0000C00;
    tick();
    chk("jal2_pc", pc, 32'h0000_3000);
    clear_inputs(); ret = 1'b1; jr_target = 32'h0000_3020;
    tick();
    chk("mp_pc", pc, 32'h0000_3020);
    chk("mp_pulse", 32'(ras_mispredict), 32'd1);
    chk("mp_unf", 32'(ras_unf), 32'd0);

    // jal together with ret: jal wins, ret ignored
    clear_inputs(); jal = 1'b1; ret = 1'b1; j_index = 26'h0000C00; jr_target = 32'h0000_3100;
    tick();
    chk("jalret_pc", pc, 32'h0000_3000);
    chk("jalret_cnt", 32'(ras_count), 32'd1);
    clear_inputs(); ret = 1'b1; jr_target = 32'h0000_3024;
    tick();
    chk("jalret_pop", pc, 32'h0000_3024);
    chk("jalret_mp", 32'(ras_mispredict), 32'd0);

    // Stall holds PC and stack; exc overrides stall
    clear_inputs(); stall = 1'b1; j = 1'b1; j_index = 26'h0000C40;
    tick();
    chk("stall_j", pc, 32'h0000_3024);
    clear_inputs(); stall = 1'b1; jal = 1'b1; j_index = 26'h0000C40;
    tick();
    chk("stall_jal_pc", pc, 32'h0000_3024);
    chk("stall_jal_cnt", 32'(ras_count), 32'd0);
    clear_inputs(); stall = 1'b1; exc = 1'b1;
    tick();
    chk("stall_exc", pc, 32'h0000_4180);
    clear_inputs(); jr = 1'b1; jr_target = 32'h0000_3006;
    tick();
    chk("misal_pc", pc, 32'h0000_3004);
    chk("misal_err", 32'(addr_err), 32'd1);
    clear_inputs();
    tick();
    chk("err_drop", 32'(addr_err), 32'd0);
    chk("err_seq", pc, 32'h0000_3008);

    // exc/eret leave the stack alone; exc beats branch and jal
    clear_inputs(); jal = 1'b1; j_index = 26'h0000C00;
    tick();
    chk("pre_exc_cnt", 32'(ras_count), 32'd1);
    clear_inputs(); exc = 1'b1; eret = 1'b1; br = 1'b1; zero = 1'b1; jal = 1'b1;
    tick();
    chk("exc_prio", pc, 32'h0000_4180);
    chk("exc_cnt", 32'(ras_count), 32'd1);
    clear_inputs(); eret = 1'b1; epc = 32'h0000_3101; jal = 1'b1;
    tick();
    chk("eret_pc", pc, 32'h0000_3100);
    chk("eret_err", 32'(addr_err), 32'd1);
    chk("eret_cnt", 32'(ras_count), 32'd1);

    // Reset beats everything
    clear_inputs(); reset = 1'b1; exc = 1'b1; stall = 1'b1;
    tick();
    chk("rst2_pc", pc, 32'h0000_3000);
    chk("rst2_cnt", 32'(ras_count), 32'd0);
    chk("rst2_err", 32'(addr_err), 32'd0);
    reset = 1'b0; clear_inputs();
    tick();
    chk("rst2_seq", pc, 32'h0000_3004);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
